// File: rtl/dummy_hls_stream_source_ctrl.sv
// rtl/dummy_hls_stream_source_ctrl.sv - TCDM read streamer feeding an HLS input channel.
// Optional stall counter on perf_stall_o when DUMMY_HLS_SRC_PERF_EN is defined.
module dummy_hls_stream_source_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SIZE_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              req_start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [SIZE_W-1:0] trans_size_i,
    input  logic [SIZE_W-1:0] line_length_i,
    input  logic [ADDR_W-1:0] line_stride_i,
    output logic              ready_start_o,
    output logic              done_o,
    output logic              tcdm_req_o,
    output logic [ADDR_W-1:0] tcdm_add_o,
    input  logic              tcdm_gnt_i,
    input  logic              tcdm_r_valid_i,
    input  logic [DATA_W-1:0] tcdm_r_data_i,
    output logic              stream_valid_o,
    output logic [DATA_W-1:0] stream_data_o,
    input  logic              stream_ready_i,
    output logic [31:0]       perf_stall_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t            state;
    logic [SIZE_W-1:0] size_q, len_q, col_q, issued_q, popped_q;
    logic [ADDR_W-1:0] stride_q, line_base_q;
    logic [CNT_W-1:0]  outstanding_q, drop_q, fifo_cnt_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic              gnt_fire, rv_live, active, push, pop, start_acc, wrap, more;
    logic [SIZE_W-1:0] col_inc;
    logic [ADDR_W-1:0] nxt_addr;
    logic [CNT_W-1:0]  fifo_cnt_nxt, out_nxt, credit_nxt;

    assign ready_start_o  = (state == IDLE) && (drop_q == '0);
    assign stream_valid_o = (fifo_cnt_q != '0);
    assign stream_data_o  = fifo_mem[rd_ptr_q];

    always_comb begin
        gnt_fire     = tcdm_req_o && tcdm_gnt_i;
        // Responses belonging to a cleared transfer are swallowed by drop_q.
        rv_live      = tcdm_r_valid_i && (drop_q == '0);
        active       = (state == ISSUE) || (state == DRAIN);
        push         = rv_live && active;
        pop          = stream_valid_o && stream_ready_i;
        start_acc    = req_start_i && ready_start_o && !clear_i;
        fifo_cnt_nxt = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        out_nxt      = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(rv_live);
        credit_nxt   = CNT_W'(FIFO_DEPTH) - fifo_cnt_nxt - out_nxt;
        more         = (issued_q + SIZE_W'(gnt_fire)) < size_q;
        col_inc      = col_q + SIZE_W'(1);
        wrap         = (len_q != '0) && (col_inc == len_q);
        nxt_addr     = wrap ? (line_base_q + stride_q) : (tcdm_add_o + WORD_BYTES);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            size_q        <= '0;
            len_q         <= '0;
            col_q         <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            stride_q      <= '0;
            line_base_q   <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tcdm_req_o    <= 1'b0;
            tcdm_add_o    <= '0;
            done_o        <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (clear_i) begin
            state         <= IDLE;
            tcdm_req_o    <= 1'b0;
            done_o        <= 1'b0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            drop_q        <= drop_q + outstanding_q + CNT_W'(gnt_fire) - CNT_W'(tcdm_r_valid_i);
        end else begin
            done_o <= 1'b0;
            if ((drop_q != '0) && tcdm_r_valid_i) drop_q <= drop_q - CNT_W'(1);
            if (push) begin
                fifo_mem[wr_ptr_q] <= tcdm_r_data_i;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                popped_q <= popped_q + SIZE_W'(1);
            end
            fifo_cnt_q    <= fifo_cnt_nxt;
            outstanding_q <= out_nxt;
            if (gnt_fire) begin
                issued_q   <= issued_q + SIZE_W'(1);
                tcdm_add_o <= nxt_addr;
                col_q      <= wrap ? '0 : col_inc;
                if (wrap) line_base_q <= line_base_q + stride_q;
            end
            case (state)
                IDLE: if (start_acc) begin
                    size_q      <= trans_size_i;
                    len_q       <= line_length_i;
                    stride_q    <= line_stride_i;
                    line_base_q <= base_addr_i;
                    tcdm_add_o  <= base_addr_i;
                    col_q       <= '0;
                    issued_q    <= '0;
                    popped_q    <= '0;
                    tcdm_req_o  <= (trans_size_i != '0);
                    state       <= (trans_size_i == '0) ? FIN : ISSUE;
                end
                ISSUE: begin
                    // A pending request holds its address until granted.
                    if (!tcdm_req_o || tcdm_gnt_i) tcdm_req_o <= more && (credit_nxt != '0);
                    if (gnt_fire && !more) state <= DRAIN;
                end
                DRAIN: if ((popped_q + SIZE_W'(pop)) == size_q) state <= FIN;
                FIN: begin
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DUMMY_HLS_SRC_PERF_EN
    logic [31:0]      perf_q;
    logic [CNT_W-1:0] credit_now;
    logic             stall_cyc;

    always_comb begin
        credit_now = CNT_W'(FIFO_DEPTH) - fifo_cnt_q - outstanding_q;
        stall_cyc  = (tcdm_req_o && !tcdm_gnt_i) || ((state == ISSUE) && (credit_now == '0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) perf_q <= '0;
        else if (clear_i || start_acc) perf_q <= '0;
        else if (stall_cyc && (perf_q != 32'hFFFF_FFFF)) perf_q <= perf_q + 32'd1;
    end

    assign perf_stall_o = perf_q;
`else
    assign perf_stall_o = 32'd0;
`endif
endmodule

// File: tb/tb_dummy_hls_stream_source_ctrl.sv
// tb/tb_dummy_hls_stream_source_ctrl.sv - scoreboard bench with a TCDM responder model.
module tb_dummy_hls_stream_source_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i, clear_i, req_start_i;
    logic [31:0] base_addr_i, line_stride_i;
    logic [15:0] trans_size_i, line_length_i;
    logic        ready_start_o, done_o, tcdm_req_o;
    logic [31:0] tcdm_add_o;
    logic        tcdm_gnt_i, tcdm_r_valid_i;
    logic [31:0] tcdm_r_data_i;
    logic        stream_valid_o, stream_ready_i;
    logic [31:0] stream_data_o, perf_stall_o;

    always #5 clk_i = ~clk_i;

    dummy_hls_stream_source_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .req_start_i(req_start_i),
        .base_addr_i(base_addr_i), .trans_size_i(trans_size_i), .line_length_i(line_length_i),
        .line_stride_i(line_stride_i), .ready_start_o(ready_start_o), .done_o(done_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_gnt_i(tcdm_gnt_i),
        .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
        .stream_valid_o(stream_valid_o), .stream_data_o(stream_data_o),
        .stream_ready_i(stream_ready_i), .perf_stall_o(perf_stall_o)
    );

    int tests = 0, fails = 0, cyc = 0, start_cyc = 0;
    int lat = 1, ready_block = 0, stall_req = -1, stall_len = 0;
    int stall_cnt, stall_bad, req_idx, done_cnt, done_cyc, last_pop_cyc, pops;
    int first_pop_grants, resp_cnt, req_seen;
    logic [31:0] stall_addr_exp, perf_at_done;
    int          due_q[$];
    logic [31:0] rdata_q[$], grant_q[$], obs_q[$], exp_addr_q[$], exp_data_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic reset_sb();
        due_q.delete(); rdata_q.delete(); grant_q.delete(); obs_q.delete();
        exp_addr_q.delete(); exp_data_q.delete();
        stall_cnt = 0; stall_bad = 0; req_idx = 0; done_cnt = 0; done_cyc = -1;
        last_pop_cyc = -1; pops = 0; first_pop_grants = -1; req_seen = 0;
        perf_at_done = '0;
    endtask

    // TCDM/stream environment: inputs change on the falling edge only.
    task automatic tick();
        @(negedge clk_i);
        cyc++;
        if (tcdm_req_o) req_seen++;
        if (done_o) begin done_cnt++; done_cyc = cyc; perf_at_done = perf_stall_o; end
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = '0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            tcdm_r_valid_i = 1'b1;
            tcdm_r_data_i  = rdata_q.pop_front();
            resp_cnt++;
        end
        tcdm_gnt_i = 1'b0;
        if (stall_cnt > 0 && stall_cnt < stall_len && !tcdm_req_o) stall_bad++;
        if (tcdm_req_o) begin
            if (req_idx == stall_req && stall_cnt < stall_len) begin
                stall_cnt++;
                if (tcdm_add_o !== stall_addr_exp) stall_bad++;
            end else begin
                tcdm_gnt_i = 1'b1;
                req_idx++;
                grant_q.push_back(tcdm_add_o);
                due_q.push_back(cyc + lat);
                rdata_q.push_back(mem_word(tcdm_add_o));
            end
        end
        if (ready_block > 0) begin stream_ready_i = 1'b0; ready_block--; end
        else stream_ready_i = 1'b1;
        if (stream_valid_o && stream_ready_i) begin
            if (pops == 0) first_pop_grants = req_idx;
            pops++;
            obs_q.push_back(stream_data_o);
            last_pop_cyc = cyc;
        end
    endtask

    task automatic start(input logic [31:0] base, input int size, input int len, input logic [31:0] stride);
        base_addr_i = base; trans_size_i = 16'(size); line_length_i = 16'(len);
        line_stride_i = stride; req_start_i = 1'b1; start_cyc = cyc;
        tick();
        req_start_i = 1'b0;
    endtask

    task automatic run_xfer(input string name, input logic [31:0] base, input int size, input int len, input logic [31:0] stride);
        logic [31:0] a, lb, got;
        int col, exp_done;
        reset_sb();
        a = base; lb = base; col = 0;
        for (int i = 0; i < size; i++) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_word(a));
            a += 32'd4; col++;
            if (len != 0 && col == len) begin col = 0; lb += stride; a = lb; end
        end
        tests++;
        if (ready_start_o !== 1'b1) begin fails++; $display("FAIL %s ready_start before: got %b need 1", name, ready_start_o); end
        start(base, size, len, stride);
        for (int t = 0; t < 400 && done_cnt == 0; t++) tick();
        tick(); tick();
        tests++;
        if (done_cnt == 0) begin fails++; $display("FAIL %s timeout: no done_o within budget", name); end
        for (int i = 0; i < size; i++) begin
            tests++;
            got = (grant_q.size() > 0) ? grant_q.pop_front() : 32'hXXXX_XXXX;
            if (got !== exp_addr_q[i]) begin fails++; $display("FAIL %s addr[%0d]: got %h need %h", name, i, got, exp_addr_q[i]); end
            tests++;
            got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hXXXX_XXXX;
            if (got !== exp_data_q[i]) begin fails++; $display("FAIL %s data[%0d]: got %h need %h", name, i, got, exp_data_q[i]); end
        end
        tests++;
        if (grant_q.size() != 0 || obs_q.size() != 0) begin
            fails++; $display("FAIL %s extra: got %0d grants %0d words beyond %0d", name, grant_q.size(), obs_q.size(), size);
        end
        exp_done = (size == 0) ? start_cyc + 2 : last_pop_cyc + 2;
        tests++;
        if (done_cnt != 1 || done_cyc != exp_done) begin
            fails++; $display("FAIL %s done: got %0d pulses at %0d need 1 at %0d", name, done_cnt, done_cyc, exp_done);
        end
        tests++;
        if (ready_start_o !== 1'b1) begin fails++; $display("FAIL %s ready_start after: got %b need 1", name, ready_start_o); end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clear_i = 0; req_start_i = 0; base_addr_i = 0; trans_size_i = 0;
        line_length_i = 0; line_stride_i = 0; tcdm_gnt_i = 0; tcdm_r_valid_i = 0;
        tcdm_r_data_i = 0; stream_ready_i = 1;
        tick(); tick();
        tests++;
        if ({ready_start_o, done_o, tcdm_req_o, stream_valid_o} !== 4'b1000 ||
            tcdm_add_o !== 0 || stream_data_o !== 0 || perf_stall_o !== 0) begin
            fails++; $display("FAIL reset: got rs=%b done=%b req=%b v=%b add=%h data=%h perf=%0d", ready_start_o,
                              done_o, tcdm_req_o, stream_valid_o, tcdm_add_o, stream_data_o, perf_stall_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_contiguous();
        lat = 1; ready_block = 0; stall_req = -1;
        run_xfer("contig", 32'h1000, 8, 0, 0);
    endtask

    task automatic test_strided();
        lat = 1; ready_block = 0; stall_req = -1;
        run_xfer("stride2d", 32'h2000, 6, 3, 32'h100);
    endtask

    task automatic test_backpressure();
        lat = 1; ready_block = 20; stall_req = -1;
        run_xfer("backpress", 32'h0800, 10, 0, 0);
        tests++;
        if (first_pop_grants != 4) begin fails++; $display("FAIL backpress grants before stall: got %0d need 4", first_pop_grants); end
        tests++;
`ifdef DUMMY_HLS_SRC_PERF_EN
        if (perf_stall_o == 0) begin fails++; $display("FAIL backpress perf: got %0d need >0", perf_stall_o); end
`else
        if (perf_stall_o !== 0) begin fails++; $display("FAIL backpress perf: got %0d need 0", perf_stall_o); end
`endif
    endtask

    task automatic test_grant_stall();
        lat = 1; ready_block = 0; stall_req = 2; stall_len = 5; stall_addr_exp = 32'h4008;
        run_xfer("gntstall", 32'h4000, 6, 0, 0);
        tests++;
        if (stall_cnt != 5 || stall_bad != 0) begin
            fails++; $display("FAIL gntstall hold: got %0d stall cycles %0d bad need 5 and 0", stall_cnt, stall_bad);
        end
`ifdef DUMMY_HLS_SRC_PERF_EN
        tests++;
        if (perf_at_done !== 32'd5) begin fails++; $display("FAIL gntstall perf: got %0d need 5", perf_at_done); end
`endif
        stall_req = -1;
    endtask

    task automatic test_zero_size();
        lat = 1; ready_block = 0; stall_req = -1;
        run_xfer("zero", 32'h9000, 0, 0, 0);
        tests++;
        if (req_seen != 0) begin fails++; $display("FAIL zero req: got %0d request cycles need 0", req_seen); end
    endtask

    task automatic test_clear_priority();
        reset_sb();
        trans_size_i = 16'd4; base_addr_i = 32'h6000; req_start_i = 1'b1; clear_i = 1'b1;
        tick();
        req_start_i = 1'b0; clear_i = 1'b0;
        tick(); tick();
        tests++;
        if (req_seen != 0 || ready_start_o !== 1'b1) begin
            fails++; $display("FAIL clrprio: got %0d req cycles rs=%b need 0 and 1", req_seen, ready_start_o);
        end
    endtask

    task automatic test_clear_outstanding();
        int rb, prev;
        lat = 4; ready_block = 0; stall_req = 2; stall_len = 50; stall_addr_exp = 32'h5008;
        reset_sb();
        start(32'h5000, 8, 0, 0);
        for (int t = 0; t < 20 && req_idx < 2; t++) tick();
        tick();
        rb = resp_cnt;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int t = 0; t < 8; t++) begin
            prev = resp_cnt;
            tick();
            tests++;
            if (ready_start_o !== ((prev - rb) >= 2) || stream_valid_o !== 1'b0 || tcdm_req_o !== 1'b0) begin
                fails++; $display("FAIL clear t%0d: got rs=%b v=%b req=%b need rs=%b v=0 req=0", t, ready_start_o,
                                  stream_valid_o, tcdm_req_o, (prev - rb) >= 2);
            end
        end
        stall_req = -1; lat = 1;
        run_xfer("clear_next", 32'h3000, 2, 0, 0);
    endtask

    initial begin
        resp_cnt = 0;
        reset_sb();
        test_reset();
        test_contiguous();
        test_strided();
        test_backpressure();
        test_grant_stall();
        test_zero_size();
        test_clear_priority();
        test_clear_outstanding();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
